// File: rtl/iob_pcx_rx_buf_if.sv
// Packet bus between the repeated CCX bus, the IOB receive buffer and the IOB core.
// master drives packets in and accepts them out; slave is the buffer itself.
interface iob_pcx_rx_buf_if #(
    parameter int unsigned WIDTH = 136,
    parameter int unsigned CNTW  = 3
);
    logic             ccx_iob_vld;
    logic [WIDTH-1:0] ccx_iob_data;
    logic             iob_ccx_stall;
    logic             iob_rx_vld;
    logic [WIDTH-1:0] iob_rx_data;
    logic             iob_rx_rdy;
    logic             iob_rx_ovf_err;
    logic [CNTW-1:0]  iob_rx_cnt;

    modport master (
        output ccx_iob_vld, ccx_iob_data, iob_rx_rdy,
        input  iob_ccx_stall, iob_rx_vld, iob_rx_data, iob_rx_ovf_err, iob_rx_cnt
    );

    modport slave (
        input  ccx_iob_vld, ccx_iob_data, iob_rx_rdy,
        output iob_ccx_stall, iob_rx_vld, iob_rx_data, iob_rx_ovf_err, iob_rx_cnt
    );
endinterface

// File: rtl/iob_pcx_rx_buf.sv
// IOB-side receive FIFO for CCX packets: in-order delivery over valid/ready,
// registered back-pressure to CCX, and a sticky flag for dropped (overflow) packets.
module iob_pcx_rx_buf #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 136,
    parameter int unsigned CNTW  = 3
) (
    input  logic               rclk,
    input  logic               reset,
    iob_pcx_rx_buf_if.slave    bus
);
    localparam int unsigned   PTRW      = $clog2(DEPTH);
    localparam logic [CNTW-1:0] FULL     = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] STALL_TH = CNTW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr;
    logic [PTRW-1:0]  rd_ptr;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_nxt;
    logic             stall_q;
    logic             ovf_q;
    logic             enq;
    logic             deq;
    logic             ovf;

    // A full FIFO still accepts a packet when the head leaves in the same cycle.
    always_comb begin
        deq       = 1'b0;
        enq       = 1'b0;
        ovf       = 1'b0;
        count_nxt = count;
        deq       = (count != '0) && bus.iob_rx_rdy;
        enq       = bus.ccx_iob_vld && ((count < FULL) || deq);
        ovf       = bus.ccx_iob_vld && !enq;
        count_nxt = count + CNTW'(enq) - CNTW'(deq);
    end

    always_ff @(posedge rclk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            stall_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTRW'(1);
            if (deq) rd_ptr <= rd_ptr + PTRW'(1);
            count <= count_nxt;
            // Threshold one below full leaves room for the packet already in flight.
            stall_q <= (count_nxt >= STALL_TH);
            if (ovf) ovf_q <= 1'b1;
        end
    end

    // Payload storage is intentionally not reset.
    always_ff @(posedge rclk) begin
        if (!reset && enq) mem[wr_ptr] <= bus.ccx_iob_data;
    end

    assign bus.iob_ccx_stall  = stall_q;
    assign bus.iob_rx_vld     = (count != '0);
    assign bus.iob_rx_data    = mem[rd_ptr];
    assign bus.iob_rx_ovf_err = ovf_q;
    assign bus.iob_rx_cnt     = count;
endmodule

// File: doc/iob_pcx_rx_buf.md
# iob_pcx_rx_buf

Receive buffer at the IOB end of the CCX→IOB 136-bit packet path. It captures packets arriving from the repeated CCX bus and queues them in a small FIFO. It presents them in order to the IOB core through a valid/ready handshake. It returns a registered stall to the CCX side so that no in-flight packet is lost, and it flags any protocol-violating overflow.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of 2, ≥ 2.
- `WIDTH`, default 136: packet width, matching the repeated CCX bus.
- `CNTW`, default 3: occupancy counter width, = log2(DEPTH)+1.

Ports:
- `rclk` in 1: clock; single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `ccx_iob_vld` in 1: packet valid on the repeated bus this cycle.
- `ccx_iob_data` in WIDTH: packet payload; output of the 136-bit repeater.
- `iob_ccx_stall` out 1: registered back-pressure to the CCX side.
- `iob_rx_vld` out 1: head entry valid toward the IOB core.
- `iob_rx_data` out WIDTH: head entry payload.
- `iob_rx_rdy` in 1: IOB core accepts the head this cycle.
- `iob_rx_ovf_err` out 1: sticky overflow error.
- `iob_rx_cnt` out CNTW: current occupancy.

## Operation
- Storage: DEPTH×WIDTH register array, a write pointer, a read pointer, and a CNTW-bit count.
  - Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH.
- Enqueue:
  - Condition: `ccx_iob_vld` && (count < DEPTH || deq).
  - Action: write `ccx_iob_data` at the write pointer, then increment the write pointer.
- Dequeue:
  - Condition: `iob_rx_vld` && `iob_rx_rdy`.
  - Action: increment the read pointer.
- Count update: count_nxt = count + enq − deq, held in 0..DEPTH.
- Simultaneous enq+deq:
  - When full, both are allowed; count stays DEPTH and FIFO order is preserved.
  - When empty, only the enq occurs, since `iob_rx_vld` = 0.
- Overflow: if `ccx_iob_vld` arrives while count == DEPTH and there is no deq:
  - the packet is dropped, and pointers and count are unchanged;
  - `iob_rx_ovf_err` goes to 1 and stays at 1 until reset.
- Combinational outputs:
  - `iob_rx_vld` = (count != 0).
  - `iob_rx_data` = entry at the read pointer, combinational from storage. Its value is don't-care while `iob_rx_vld` = 0.
  - `iob_rx_cnt` = count.
- Stall: `iob_ccx_stall` is a flop that loads (count_nxt ≥ DEPTH−1) every cycle.
- Upstream contract: a packet may arrive in cycle N only if `iob_ccx_stall` was 0 in cycle N−1. Under this contract overflow cannot occur.
- No FSM beyond the FIFO state; storage contents are not reset.

## Timing
- Reset, synchronous: at the first `rclk` edge with `reset` = 1:
  - count = 0 and both pointers = 0;
  - `iob_ccx_stall` = 0, `iob_rx_ovf_err` = 0, `iob_rx_vld` = 0, `iob_rx_cnt` = 0.
- Reset dominates any enq/deq in the same cycle. Packets in flight during reset are discarded.
- Latency: a packet enqueued at the edge ending cycle N is visible on `iob_rx_vld`/`iob_rx_data` in cycle N+1.
- Dequeue takes effect at the edge where vld && rdy. The next entry, or vld = 0, is visible the following cycle.
- `iob_ccx_stall` reflects occupancy one edge later. One packet may still arrive in the first cycle the stall is high; the DEPTH−1 threshold guarantees room for it.
- `iob_rx_rdy` is legal while `iob_rx_vld` = 0 and is ignored.
- Throughput: one enq and one deq per cycle sustained; no bubbles when rdy is held at 1.

## Test plan
All scenarios use DEPTH = 4.
1. Reset: hold `reset` = 1 for 2 cycles with random `ccx_iob_vld`/`iob_rx_rdy` → vld = 0, stall = 0, ovf_err = 0, cnt = 0 on the cycle after release.
2. Single packet: `ccx_iob_vld` = 1 with data `136'hA5…5A` in cycle 1 and rdy = 1 → vld = 1 with that data in cycle 2, cnt = 1; vld = 0 and cnt = 0 in cycle 3.
3. Fill with stall: rdy = 0, push P0..P2 in cycles 1–3 → stall = 1 from cycle 4.
   - Push P3 in cycle 4, which is legal → cnt = 4 in cycle 5.
   - Then rdy = 1 → P0..P3 come out in order.
   - Stall drops the cycle after cnt_nxt < 3.
4. Overflow: with cnt = 4 and rdy = 0, drive `ccx_iob_vld` with P4 → cnt stays 4, ovf_err = 1 and stays sticky; dequeue yields P0..P3 only.
5. Full + simultaneous: with cnt = 4, drive vld and rdy in the same cycle → cnt stays 4, ovf_err = 0, and the new packet comes out after the existing three.
6. Wrap-around: stream 20 packets (incrementing payload) with pseudo-random rdy while obeying the stall contract → exact in-order output, no drops, ovf_err = 0, pointers wrap at least 4 times.
